// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and default sizes for the register file with issue scoreboard.
package regfile_scoreboard_pkg;

   localparam int DEFAULT_DATA_W = 64;
   localparam int DEFAULT_ADDR_W = 5;

   typedef enum logic {
      CLEAR,
      RUN
   } state_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: picks same-cycle write data over stored data, port 1 first,
// and masks the hardwired zero register and the not-yet-ready state.
module regfile_bypass_mux
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic              run_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic              store_busy_i,
   input  logic              wr_en0_i,
   input  logic [ADDR_W-1:0] wr_addr0_i,
   input  logic [DATA_W-1:0] wr_data0_i,
   input  logic              wr_en1_i,
   input  logic [ADDR_W-1:0] wr_addr1_i,
   input  logic [DATA_W-1:0] wr_data1_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_busy_o
);

   logic zeroHit;

   assign zeroHit = (ZERO_REG != 0) && (rd_addr_i == '0);

   // A register being written this cycle is by definition no longer pending.
   always_comb begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
      if (run_i && !zeroHit) begin
         if (wr_en1_i && (wr_addr1_i == rd_addr_i)) begin
            rd_data_o = wr_data1_i;
         end else if (wr_en0_i && (wr_addr0_i == rd_addr_i)) begin
            rd_data_o = wr_data0_i;
         end else begin
            rd_data_o = store_data_i;
            rd_busy_o = store_busy_i;
         end
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-write, two-read register file with a per-register busy scoreboard,
// cleared one entry per cycle after reset before accepting traffic.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en0,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              ready
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clrIdx_q, clrIdx_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;

   logic run;
   logic wrOk0, wrOk1, rsvOk;

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
   end

   always_comb begin
      state_d  = state_q;
      clrIdx_d = clrIdx_q;
      if (reset) begin
         state_d  = CLEAR;
         clrIdx_d = '0;
      end else begin
         case (state_q)
            CLEAR: begin
               clrIdx_d = clrIdx_q + ADDR_W'(1);
               if (&clrIdx_q) begin
                  state_d = RUN;
               end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
         endcase
      end
   end

   assign run   = (state_q == RUN) && !reset;
   assign ready = run;

   // Index 0 swallows writes and reservations when it is the hardwired zero.
   assign wrOk0 = run && wr_en0 && !((ZERO_REG != 0) && (wr_addr0 == '0));
   assign wrOk1 = run && wr_en1 && !((ZERO_REG != 0) && (wr_addr1 == '0));
   assign rsvOk = run && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

   // Later assignments win: port 1 over port 0, reservation over write-clear.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == CLEAR)) begin
         regs_q[clrIdx_q] <= '0;
         busy_q[clrIdx_q] <= 1'b0;
      end else begin
         if (wrOk0) begin
            regs_q[wr_addr0] <= wr_data0;
            busy_q[wr_addr0] <= 1'b0;
         end
         if (wrOk1) begin
            regs_q[wr_addr1] <= wr_data1;
            busy_q[wr_addr1] <= 1'b0;
         end
         if (rsvOk) begin
            busy_q[rsv_addr] <= 1'b1;
         end
      end
   end

   regfile_bypass_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
   ) u_rdMux1 (
      .run_i       (run),
      .rd_addr_i   (rd_addr1),
      .store_data_i(regs_q[rd_addr1]),
      .store_busy_i(busy_q[rd_addr1]),
      .wr_en0_i    (wr_en0),
      .wr_addr0_i  (wr_addr0),
      .wr_data0_i  (wr_data0),
      .wr_en1_i    (wr_en1),
      .wr_addr1_i  (wr_addr1),
      .wr_data1_i  (wr_data1),
      .rd_data_o   (rd_data1),
      .rd_busy_o   (rd_busy1)
   );

   regfile_bypass_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
   ) u_rdMux2 (
      .run_i       (run),
      .rd_addr_i   (rd_addr2),
      .store_data_i(regs_q[rd_addr2]),
      .store_busy_i(busy_q[rd_addr2]),
      .wr_en0_i    (wr_en0),
      .wr_addr0_i  (wr_addr0),
      .wr_data0_i  (wr_data0),
      .wr_en1_i    (wr_en1),
      .wr_addr1_i  (wr_addr1),
      .wr_data1_i  (wr_data1),
      .rd_data_o   (rd_data2),
      .rd_busy_o   (rd_busy2)
   );

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register-index width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 The block SHALL have the port clk  in  1  clock; all state updates on rising edge.
REQ-005 The block SHALL have the port reset  in  1  reset: synchronous, active-high.
REQ-006 The block SHALL have the ports rd_addr1, rd_addr2  in  ADDR_W  read indices.
REQ-007 The block SHALL have the ports rd_data1, rd_data2  out  DATA_W  read data, combinational.
REQ-008 The block SHALL have the ports rd_busy1, rd_busy2  out  1  scoreboard busy bit of the addressed register.
REQ-009 The block SHALL have the ports wr_en0, wr_en1  in  1  write enables, ports 0 and 1.
REQ-010 The block SHALL have the ports wr_addr0, wr_addr1  in  ADDR_W  write indices.
REQ-011 The block SHALL have the ports wr_data0, wr_data1  in  DATA_W  write data.
REQ-012 The block SHALL have the port rsv_en  in  1  reserve-destination strobe (instruction issue).
REQ-013 The block SHALL have the port rsv_addr  in  ADDR_W  register to mark busy.
REQ-014 The block SHALL have the port ready  out  1  high when the clear sequence is complete and the block accepts traffic.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR (writes one zero per cycle at index clr_idx, ready=0) and RUN (ready=1).
REQ-016 In CLEAR, the block SHALL zero register clr_idx and its busy bit each cycle and increment clr_idx, entering RUN on the edge that clears index NUM_REGS-1 (NUM_REGS cycles total).
REQ-017 In CLEAR, the block SHALL ignore wr_en0/1 and rsv_en and SHALL drive rd_data1/2 = 0 and rd_busy1/2 = 0.
REQ-018 In RUN, the block SHALL update the register at wr_addrN with wr_dataN on the edge where wr_enN=1, and SHALL clear its busy bit.
REQ-019 When both write ports target the same address in one cycle, the block SHALL let port 1 win.
REQ-020 In RUN, the block SHALL provide write-to-read bypass: if wr_enN=1 and wr_addrN equals rd_addrK, rd_dataK SHALL equal wr_dataN in the same cycle (port 1 priority) and rd_busyK SHALL read 0.
REQ-021 On rsv_en=1 the block SHALL set busy[rsv_addr] at the next edge; busy is visible on rd_busy the following cycle (no bypass).
REQ-022 When rsv_en and a write hit the same address in one cycle, the block SHALL keep the busy bit set (reservation wins; data still written).
REQ-023 With ZERO_REG=1, the block SHALL read index 0 as 0 with busy 0, and SHALL ignore writes and reservations to index 0 (no bypass from index 0).
REQ-024 With ZERO_REG=0, the block SHALL treat index 0 as an ordinary register.

Reset
REQ-025 Asserting reset SHALL enter CLEAR with clr_idx=0 at the next edge, including mid-CLEAR (the sequence restarts) and mid-RUN.
REQ-026 While reset or CLEAR is active, ready SHALL be 0, rd_data1/2 SHALL be 0 and rd_busy1/2 SHALL be 0.
REQ-027 The block SHALL NOT reset storage in a single cycle; only the CLEAR sequence zeroes it.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (CLEAR, RUN) and the default DATA_W and ADDR_W constants.
REQ-029 The block SHALL instantiate one sub-module, regfile_bypass_mux, per read port, performing the address compare, port priority and zero-register masking.
REQ-030 Storage SHALL be a flop array NUM_REGS x DATA_W plus a NUM_REGS-bit busy vector.

Verification
REQ-031 Reset pulse, then idle -> ready=0 for exactly 32 cycles, then 1; reads of all 32 registers return 0 with busy 0.
REQ-032 In RUN, write r5=64'hDEAD_BEEF on port 0 with rd_addr1=5 in the same cycle -> rd_data1=64'hDEAD_BEEF that cycle; still read back the next cycle.
REQ-033 Both ports write r7 (port 0 = 64'h1, port 1 = 64'h2) -> rd_data for r7 is 64'h2 the same cycle and afterwards.
REQ-034 rsv_en on r9 -> rd_busy=1 for r9 from the following cycle; port 1 writes r9 -> busy 0 from the following cycle; rsv_en plus write on r9 in one cycle -> busy stays 1.
REQ-035 Write 64'hFF to r0 with rsv_en on r0 (ZERO_REG=1) -> r0 reads 0 with busy 0; in the same cycle, read bypass on r0 is 0.
REQ-036 Reset asserted at clear cycle 10 -> ready stays 0 for a full 32 cycles after reset deasserts; writes during that window are lost.
